// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: the loader owns the port during BOOT,
// then fetch and loader share it in RUN with a bounded loader-priority window.
module imem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              f_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_mode
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Grant decision; reset suppresses all grants so the memory sees no access.
  always_comb begin
    f_gnt  = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (state == BOOT) begin
        ld_gnt = ld_req;
      end else if (f_req && ld_req) begin
        f_gnt  = (starve_cnt >= CNT_MAX);
        ld_gnt = (starve_cnt <  CNT_MAX);
      end else begin
        f_gnt  = f_req;
        ld_gnt = ld_req;
      end
    end
  end

  always_comb begin
    mem_en    = f_gnt | ld_gnt;
    mem_we    = ld_gnt & ld_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr  = f_addr;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign f_stall   = f_req & ~f_gnt;
  assign rdata     = mem_rdata;
  assign boot_mode = (state == BOOT);

  // Registered state, starvation counter and read-return flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      starve_cnt <= '0;
      f_rvalid   <= 1'b0;
      ld_rvalid  <= 1'b0;
    end else begin
      f_rvalid  <= f_gnt;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (state == BOOT && ld_done) begin
        state <= RUN;
      end
      // Only a RUN-state loader win while fetch waits counts toward starvation.
      if (f_gnt || !f_req) begin
        starve_cnt <= '0;
      end else if (state == RUN && ld_gnt) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios then randomized traffic,
// all checked against a cycle-level behavioural model with its own memory image.
module tb_imem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst, f_req, f_gnt, f_stall, f_rvalid;
  logic [AW-1:0] f_addr, ld_addr, mem_addr;
  logic          ld_req, ld_we, ld_done, ld_gnt, ld_rvalid;
  logic [DW-1:0] ld_wdata, rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, boot_mode;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_stall(f_stall), .f_rvalid(f_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .boot_mode(boot_mode)
  );

  // Memory attached to the DUT port
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  bit            booted;
  int            wait_cnt;
  bit            exp_f_rv, exp_ld_rv;
  logic [DW-1:0] exp_rd;
  bit            eg_f, eg_ld;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit fr, input logic [AW-1:0] fa,
                       input bit lr, input bit lw, input logic [AW-1:0] la,
                       input logic [DW-1:0] lwd, input bit ldn);
    logic [AW-1:0] ea;
    @(negedge clk);
    rst = r; f_req = fr; f_addr = fa; ld_req = lr; ld_we = lw;
    ld_addr = la; ld_wdata = lwd; ld_done = ldn;
    #1;
    if (r) begin
      eg_f = 0; eg_ld = 0;
    end else if (!booted) begin
      eg_f = 0; eg_ld = lr;
    end else if (fr && lr) begin
      eg_f = (wait_cnt >= LIM); eg_ld = !eg_f;
    end else begin
      eg_f = fr; eg_ld = lr;
    end
    ea = eg_f ? fa : (eg_ld ? la : '0);
    check_eq("f_gnt", f_gnt, eg_f);
    check_eq("ld_gnt", ld_gnt, eg_ld);
    check_eq("f_stall", f_stall, fr && !eg_f);
    check_eq("boot_mode", boot_mode, !booted);
    check_eq("mem_en", mem_en, eg_f || eg_ld);
    check_eq("mem_we", mem_we, eg_ld && lw);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, eg_ld ? lwd : '0);
    check_eq("f_rvalid", f_rvalid, exp_f_rv);
    check_eq("ld_rvalid", ld_rvalid, exp_ld_rv);
    if (exp_f_rv || exp_ld_rv) check_eq("rdata", rdata, exp_rd);
    // advance model to the next cycle
    if (r) begin
      booted = 0; wait_cnt = 0; exp_f_rv = 0; exp_ld_rv = 0;
    end else begin
      exp_f_rv  = eg_f;
      exp_ld_rv = eg_ld && !lw;
      if (eg_f || (eg_ld && !lw)) exp_rd = ref_mem[ea[7:0]];
      if (eg_ld && lw) ref_mem[la[7:0]] = lwd;
      if (!fr || eg_f) wait_cnt = 0;
      else if (booted && eg_ld) wait_cnt = (wait_cnt + 1 > LIM) ? LIM : wait_cnt + 1;
      if (!booted && ldn) booted = 1;
    end
  endtask

  task automatic idle();
    cycle(0, 0, '0, 0, 0, '0, '0, 0);
  endtask

  bit            rr, rf, rl, rlw, rdn, hf, hl;
  logic [AW-1:0] rfa, rla;
  logic [DW-1:0] rlwd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1; f_req = 0; f_addr = '0; ld_req = 0; ld_we = 0;
    ld_addr = '0; ld_wdata = '0; ld_done = 0;
    repeat (2) @(negedge clk);
    booted = 0; wait_cnt = 0; exp_f_rv = 0; exp_ld_rv = 0; exp_rd = '0;

    // reset state
    cycle(1, 0, '0, 0, 0, '0, '0, 0);
    idle();
    check_eq("rst_starve_cnt", 64'(dut.starve_cnt), 0);

    // boot blocking
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 32'h0, 0, 0, '0, '0, 0);
      check_eq("boot_blk_gnt", f_gnt, 0);
      check_eq("boot_blk_stall", f_stall, 1);
    end

    // boot load with ld_done in the same cycle
    cycle(0, 1, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF, 1);
    check_eq("boot_ld_we", mem_we, 1);
    cycle(0, 1, 32'h0, 0, 0, '0, '0, 0);
    check_eq("run_boot_mode", boot_mode, 0);
    check_eq("run_first_fgnt", f_gnt, 1);

    // fetch read
    cycle(0, 1, 32'h10, 0, 0, '0, '0, 0);
    check_eq("fetch_addr", mem_addr, 32'h10);
    idle();
    check_eq("fetch_rvalid", f_rvalid, 1);
    check_eq("fetch_rdata", rdata, 32'hDEADBEEF);

    // starvation window: loader writes to distinct words, fetch every 5th cycle
    for (int i = 0; i < 15; i++) begin
      cycle(0, 1, 32'h10, 1, 1, 32'h20 + i, 32'hA000 + i, 0);
      check_eq("starve_pat", f_gnt, (i % 5) == 4);
    end

    // loader read
    cycle(0, 0, '0, 1, 0, 32'h10, '0, 0);
    check_eq("ldrd_gnt", ld_gnt, 1);
    idle();
    check_eq("ldrd_rvalid", ld_rvalid, 1);
    check_eq("ldrd_frvalid", f_rvalid, 0);
    check_eq("ldrd_rdata", rdata, 32'hDEADBEEF);

    // mid-operation reset right after a fetch grant
    cycle(0, 1, 32'h10, 0, 0, '0, '0, 0);
    cycle(1, 1, 32'h10, 1, 0, 32'h10, '0, 1);
    check_eq("rst_mem_en", mem_en, 0);
    idle();
    check_eq("rst_frvalid", f_rvalid, 0);
    check_eq("rst_boot_mode", boot_mode, 1);
    check_eq("rst_starve_cnt2", 64'(dut.starve_cnt), 0);

    // randomized traffic; requesters hold their request until granted
    hf = 0; hl = 0;
    rf = 0; rl = 0; rlw = 0; rfa = '0; rla = '0; rlwd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hf) begin
        rf  = ($urandom_range(0, 2) != 0);
        rfa = $urandom;
      end
      if (!hl) begin
        rl   = ($urandom_range(0, 2) != 0);
        rlw  = $urandom_range(0, 1) != 0;
        rla  = $urandom;
        rlwd = $urandom;
      end
      rr  = ($urandom_range(0, 49) == 0);
      rdn = ($urandom_range(0, 19) == 0);
      cycle(rr, rf, rfa, rl, rlw, rla, rlwd, rdn);
      hf = rf && !eg_f;
      hl = rl && !eg_ld;
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data and instruction word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive loader grants allowed while fetch waits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 SHALL have port f_req, input, 1 bit, the fetch read request.
REQ-007 SHALL have port f_addr, input, ADDR_W bits, the fetch PC.
REQ-008 SHALL have port f_gnt, output, 1 bit, the fetch granted this cycle.
REQ-009 SHALL have port f_stall, output, 1 bit, the fetch stall to the IF stage.
REQ-010 SHALL have port f_rvalid, output, 1 bit, meaning rdata holds the fetch instruction.
REQ-011 SHALL have port ld_req, input, 1 bit, the loader request.
REQ-012 SHALL have port ld_we, input, 1 bit, the loader write enable; 0 means read.
REQ-013 SHALL have port ld_addr, input, ADDR_W bits, the loader address.
REQ-014 SHALL have port ld_wdata, input, DATA_W bits, the loader write data.
REQ-015 SHALL have port ld_done, input, 1 bit, a pulse marking program load complete.
REQ-016 SHALL have port ld_gnt, output, 1 bit, the loader granted this cycle.
REQ-017 SHALL have port ld_rvalid, output, 1 bit, meaning rdata holds the loader read data.
REQ-018 SHALL have port rdata, output, DATA_W bits, the read data, a pass-through of mem_rdata.
REQ-019 SHALL have ports mem_en, mem_we, mem_addr and mem_wdata as outputs of 1, 1, ADDR_W and DATA_W bits, forming the single memory port.
REQ-020 SHALL have port mem_rdata, input, DATA_W bits, the memory read data, valid one cycle after mem_en with mem_we=0.
REQ-021 SHALL have port boot_mode, output, 1 bit, high while in state BOOT.

Function
REQ-022 SHALL implement two states, BOOT and RUN; boot_mode = (state==BOOT).
REQ-023 SHALL, in BOOT, hold f_gnt=0 and set ld_gnt=ld_req.
REQ-024 SHALL move BOOT->RUN on the edge where ld_done=1; a same-cycle ld_req is still granted under BOOT rules.
REQ-025 SHALL ignore ld_done in RUN; RUN exits only on rst.
REQ-026 SHALL, in RUN with one requester active, grant that requester.
REQ-027 SHALL, in RUN with both active, grant fetch if starve_cnt >= STARVE_LIMIT, else grant loader.
REQ-028 SHALL compute grants combinationally from state, requests and starve_cnt; at most one grant per cycle.
REQ-029 SHALL, when loader wins contention, increment starve_cnt (saturating at STARVE_LIMIT); fetch grant or f_req=0 clears it; other cycles hold it.
REQ-030 SHALL size starve_cnt as $clog2(STARVE_LIMIT+1) bits, minimum 1; STARVE_LIMIT=0 makes fetch win every contention.
REQ-031 SHALL drive mem_en = f_gnt|ld_gnt and mem_we = ld_gnt&ld_we; mem_addr and mem_wdata come from the granted requester, else zero.
REQ-032 SHALL register f_rvalid <= f_gnt and ld_rvalid <= ld_gnt&~ld_we; loader writes produce no rvalid.
REQ-033 SHALL drive f_stall = f_req & ~f_gnt, so IF holds its PC while not granted.
REQ-034 SHALL require requesters to hold req/addr/wdata stable until granted; the block SHALL NOT queue requests.

Reset
REQ-035 SHALL, on rst, set state=BOOT, starve_cnt=0, f_rvalid=0 and ld_rvalid=0.
REQ-036 SHALL let rst win over ld_done and grants in the same cycle; an in-flight read's rvalid is dropped, and mem_en=0 during the rst cycle.
REQ-037 SHALL, after reset in BOOT with no ld_req, output f_gnt=0, ld_gnt=0, mem_en=0, and f_stall=f_req.

Verification
REQ-038 SHALL test boot blocking: rst, then f_req=1 with f_addr=0 for 5 cycles -> f_gnt=0, f_stall=1, boot_mode=1, mem_en=0.
REQ-039 SHALL test boot load: write ld_addr=0x10 with ld_wdata=0xDEADBEEF, then ld_done -> mem_we=1 that cycle; next cycle boot_mode=0 and f_gnt=1 if f_req.
REQ-040 SHALL test fetch read: in RUN, f_req=1 with f_addr=0x10 -> f_gnt=1, mem_addr=0x10; next cycle f_rvalid=1 and rdata=0xDEADBEEF.
REQ-041 SHALL test starvation: STARVE_LIMIT=4, both requesting continuously -> ld_gnt for 4 cycles, f_gnt on the 5th, pattern repeats.
REQ-042 SHALL test loader read: ld_we=0, ld_addr=0x10, f_req=0 -> ld_gnt=1; next cycle ld_rvalid=1, f_rvalid=0, rdata=0xDEADBEEF.
REQ-043 SHALL test mid-operation reset: rst during RUN with a fetch grant -> next cycle f_rvalid=0, boot_mode=1, starve_cnt=0.
